// File: rtl/rr_encoder8to3_if.sv
// Handshake bundle between the round-robin request encoder and its consumer.
// The master side is the encoder; the slave side drives requests and ready.
interface rr_encoder8to3_if;
   logic [7:0] req;
   logic       ready;
   logic       o2;
   logic       o1;
   logic       o0;
   logic       valid;
   logic       pend_any;

   modport master (
      input  req,
      input  ready,
      output o2,
      output o1,
      output o0,
      output valid,
      output pend_any
   );

   modport slave (
      output req,
      output ready,
      input  o2,
      input  o1,
      input  o0,
      input  valid,
      input  pend_any
   );
endinterface

// File: rtl/rr_encoder8to3.sv
// Round-robin 8-to-3 request encoder with a registered output slot.
// Requests are optionally latched until granted. The winner's index is held
// in an output register guarded by a valid/ready handshake. A request is
// retired as soon as its index is loaded into that register.
module rr_encoder8to3 #(
   parameter bit         STICKY     = 1'b1,
   parameter logic [2:0] LAST_RESET = 3'd7
) (
   input  logic            clk,
   input  logic            rst,
   rr_encoder8to3_if.master bus
);

   logic [7:0] r_pend;
   logic [2:0] r_ptr;
   logic [2:0] r_code;
   logic       r_valid;

   logic [7:0] w_eff;
   logic       w_free;
   logic [3:0] w_find;
   logic       w_found;
   logic [2:0] w_idx;
   logic       w_load;
   logic [7:0] w_clr;

   // Search eff starting at ptr+1 and wrapping; ptr itself is examined last.
   // Bit 3 of the result flags a hit, bits 2:0 carry the winning index.
   function automatic logic [3:0] f_find(input logic [7:0] eff, input logic [2:0] ptr);
      logic [3:0] res;
      logic [2:0] k;
      res = '0;
      for (int i = 8; i >= 1; i--) begin
         k = ptr + 3'(i);
         if (eff[k]) res = {1'b1, k};
      end
      return res;
   endfunction

   assign w_eff   = STICKY ? (r_pend | bus.req) : bus.req;
   assign w_free  = !r_valid || bus.ready;
   assign w_find  = f_find(w_eff, r_ptr);
   assign w_found = w_find[3];
   assign w_idx   = w_find[2:0];
   assign w_load  = w_free && w_found;

   // Clear mask for the pending set: only the index being loaded this edge.
   always_comb begin
      w_clr = '0;
      if (w_load) w_clr[w_idx] = 1'b1;
   end

   // Output slot and priority pointer: load a winner whenever the slot is free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_code  <= 3'b000;
         r_ptr   <= LAST_RESET;
      end else if (w_free) begin
         if (w_found) begin
            r_code  <= w_idx;
            r_valid <= 1'b1;
            r_ptr   <= w_idx;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   generate
      if (STICKY) begin : g_sticky
         // Pending set: accumulate request pulses; clearing beats a same-edge set.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) r_pend <= '0;
            else     r_pend <= (r_pend | bus.req) & ~w_clr;
         end
      end else begin : g_level
         assign r_pend = '0;
      end
   endgenerate

   assign bus.o2       = r_code[2];
   assign bus.o1       = r_code[1];
   assign bus.o0       = r_code[0];
   assign bus.valid    = r_valid;
   assign bus.pend_any = STICKY ? |r_pend : 1'b0;

endmodule
